// File: rtl/static_priority_selector_pkg.sv
// -----------------------------------------------------------------------------
// static_priority_selector_pkg
//
// Shared constants and helpers for the static priority selector slice.
//   - DEFAULT_DEPTH / DEFAULT_ENQ_WIDTH / DEFAULT_SEL_WIDTH : default sizing
//   - prefix_cnt_width(n) : bits needed to hold a prefix popcount over the
//                           first n-1 bits of an n-bit vector (never zero)
// -----------------------------------------------------------------------------
package static_priority_selector_pkg;

  localparam int DEFAULT_DEPTH     = 8;
  localparam int DEFAULT_ENQ_WIDTH = 2;
  localparam int DEFAULT_SEL_WIDTH = 2;

  // A prefix count at bit i covers bits [i-1:0], so it never exceeds n-1.
  // Clamp to one bit so a single-entry instance still gets a legal vector.
  function automatic int prefix_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/static_kth_one_finder.sv
// -----------------------------------------------------------------------------
// static_kth_one_finder
//
// Purely combinational: for each k in [0, Width), produces a one-hot mask
// marking the (k+1)-th set bit of vec, counting from index 0 upward. A slot
// is all-zero when vec has fewer than k+1 set bits.
//
// Ports:
//   vec  : input  [Depth-1:0]             candidate bits
//   mask : output [Width-1:0][Depth-1:0]  slot k = one-hot of the (k+1)-th one
// -----------------------------------------------------------------------------
module static_kth_one_finder
  import static_priority_selector_pkg::*;
#(
  parameter int Depth = DEFAULT_DEPTH,
  parameter int Width = DEFAULT_ENQ_WIDTH
) (
  input  logic [Depth-1:0]            vec,
  output logic [Width-1:0][Depth-1:0] mask
);

  localparam int CntWidth = prefix_cnt_width(Depth);

  // prefix[i] = number of ones in vec[i-1:0]
  logic [CntWidth-1:0] prefix [Depth];

  genvar gi, gj;

  for (gi = 0; gi < Depth; gi++) begin : g_prefix
    if (gi == 0) begin : g_first
      assign prefix[gi] = '0;
    end else begin : g_rest
      assign prefix[gi] = prefix[gi-1] + CntWidth'(vec[gi-1]);
    end
  end

  // A set bit whose prefix count equals k is exactly the (k+1)-th one, which
  // makes every slot one-hot and the slots disjoint and ordered by index.
  for (gi = 0; gi < Width; gi++) begin : g_slot
    for (gj = 0; gj < Depth; gj++) begin : g_bit
      assign mask[gi][gj] = vec[gj] && (int'(prefix[gj]) == gi);
    end
  end

endmodule

// File: rtl/static_priority_selector.sv
// -----------------------------------------------------------------------------
// static_priority_selector
//
// Multi-port static-priority picker for queue control. Finds the EnqWidth
// lowest-indexed free entries (entry_vld_i == 0) and the SelWidth
// lowest-indexed requesting entries (sel_mask_i == 1). sel_mask_i is not
// qualified by entry_vld_i; the caller keeps it a subset of the valid bits.
//
// Ports:
//   clk           : clock, only used by the optional output register
//   rst_n         : asynchronous active-low reset of the optional register
//   entry_vld_i   : [Depth-1:0] per-entry occupied bits
//   sel_mask_i    : [Depth-1:0] per-entry selection requests
//   enq_mask_o    : [EnqWidth-1:0][Depth-1:0] slot k = (k+1)-th free entry
//   result_mask_o : [SelWidth-1:0][Depth-1:0] slot k = (k+1)-th request
//
// Build option:
//   STATIC_PRIO_SEL_OUT_REG_EN - when defined, both outputs are registered
//   (one cycle latency, cleared asynchronously by rst_n). When undefined the
//   block is purely combinational and clk/rst_n are ignored.
// -----------------------------------------------------------------------------
module static_priority_selector
  import static_priority_selector_pkg::*;
#(
  parameter int Depth    = DEFAULT_DEPTH,
  parameter int EnqWidth = DEFAULT_ENQ_WIDTH,
  parameter int SelWidth = DEFAULT_SEL_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [Depth-1:0]              entry_vld_i,
  input  logic [Depth-1:0]              sel_mask_i,
  output logic [EnqWidth-1:0][Depth-1:0] enq_mask_o,
  output logic [SelWidth-1:0][Depth-1:0] result_mask_o
);

  localparam int PtrWidth = $clog2(Depth);

  logic [EnqWidth-1:0][Depth-1:0] enq_mask_next;
  logic [SelWidth-1:0][Depth-1:0] result_mask_next;

  // Free entries are the zeros of the valid vector.
  static_kth_one_finder #(
    .Depth (Depth),
    .Width (EnqWidth)
  ) u_enq_finder (
    .vec  (~entry_vld_i),
    .mask (enq_mask_next)
  );

  static_kth_one_finder #(
    .Depth (Depth),
    .Width (SelWidth)
  ) u_sel_finder (
    .vec  (sel_mask_i),
    .mask (result_mask_next)
  );

  // No pointer output is produced; the width is kept for wrappers that
  // derive encoded indices from these masks.
  logic [31:0] unused_ptr_width;
  assign unused_ptr_width = 32'(PtrWidth);

`ifdef STATIC_PRIO_SEL_OUT_REG_EN
  logic [EnqWidth-1:0][Depth-1:0] enq_mask_reg;
  logic [SelWidth-1:0][Depth-1:0] result_mask_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enq_mask_reg    <= '0;
      result_mask_reg <= '0;
    end else begin
      enq_mask_reg    <= enq_mask_next;
      result_mask_reg <= result_mask_next;
    end
  end

  assign enq_mask_o    = enq_mask_reg;
  assign result_mask_o = result_mask_reg;
`else
  // Combinational build: clock and reset are intentionally left unused.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign enq_mask_o    = enq_mask_next;
  assign result_mask_o = result_mask_next;
`endif

endmodule

// File: tb/tb_static_priority_selector.sv
// -----------------------------------------------------------------------------
// tb_static_priority_selector
//
// Self-checking bench for static_priority_selector (Depth=8, widths 2).
// A scan-based reference model predicts every output slot each cycle; a few
// directed vectors pin both the model and the DUT to hand-computed values.
// Handles both the combinational build and STATIC_PRIO_SEL_OUT_REG_EN.
// -----------------------------------------------------------------------------
module tb_static_priority_selector;

  localparam int D  = 8;
  localparam int EW = 2;
  localparam int SW = 2;
  localparam int NUM_RANDOM = 20000;

  logic                   clk;
  logic                   rst_n;
  logic [D-1:0]           entry_vld;
  logic [D-1:0]           sel_mask;
  logic [EW-1:0][D-1:0]   enq_mask;
  logic [SW-1:0][D-1:0]   result_mask;

  int errors = 0;
  int checks = 0;

  static_priority_selector #(
    .Depth    (D),
    .EnqWidth (EW),
    .SelWidth (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_vld_i   (entry_vld),
    .sel_mask_i    (sel_mask),
    .enq_mask_o    (enq_mask),
    .result_mask_o (result_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: walk the entries from index 0 upward, hand each
  // candidate to the next unfilled slot, drop candidates once slots run out.
  function automatic logic [EW-1:0][D-1:0] pick_free(input logic [D-1:0] vld);
    logic [EW-1:0][D-1:0] m;
    int slot;
    m = '0;
    slot = 0;
    for (int i = 0; i < D; i++) begin
      if (!vld[i]) begin
        if (slot < EW) m[slot][i] = 1'b1;
        slot++;
      end
    end
    return m;
  endfunction

  function automatic logic [SW-1:0][D-1:0] pick_req(input logic [D-1:0] req);
    logic [SW-1:0][D-1:0] m;
    int slot;
    m = '0;
    slot = 0;
    for (int i = 0; i < D; i++) begin
      if (req[i]) begin
        if (slot < SW) m[slot][i] = 1'b1;
        slot++;
      end
    end
    return m;
  endfunction

  task automatic chk(input string name, input int slot,
                     input logic [D-1:0] act, input logic [D-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s slot%0d: got %b expected %b (vld=%b sel=%b)",
               name, slot, act, exp, entry_vld, sel_mask);
    end
  endtask

  // Expected outputs: in the registered build, the model result passes
  // through a one-cycle stage cleared by reset, like the outputs themselves.
  logic [EW-1:0][D-1:0] exp_enq;
  logic [SW-1:0][D-1:0] exp_res;
`ifdef STATIC_PRIO_SEL_OUT_REG_EN
  logic [EW-1:0][D-1:0] pipe_enq;
  logic [SW-1:0][D-1:0] pipe_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_enq <= '0;
      pipe_res <= '0;
    end else begin
      pipe_enq <= pick_free(entry_vld);
      pipe_res <= pick_req(sel_mask);
    end
  end
`endif

  // Literal expectations for directed vectors, checked by the compare process.
  bit                    chk_en = 1'b0;
  bit                    lit_en = 1'b0;
  string                 lit_name;
  logic [EW-1:0][D-1:0]  lit_enq;
  logic [SW-1:0][D-1:0]  lit_res;

  always @(negedge clk) begin
    if (chk_en) begin
`ifdef STATIC_PRIO_SEL_OUT_REG_EN
      exp_enq = pipe_enq;
      exp_res = pipe_res;
`else
      exp_enq = pick_free(entry_vld);
      exp_res = pick_req(sel_mask);
`endif
      for (int k = 0; k < EW; k++) chk("model_enq", k, enq_mask[k], exp_enq[k]);
      for (int k = 0; k < SW; k++) chk("model_res", k, result_mask[k], exp_res[k]);
      if (lit_en) begin
        for (int k = 0; k < EW; k++) chk({lit_name, "_enq"}, k, enq_mask[k], lit_enq[k]);
        for (int k = 0; k < SW; k++) chk({lit_name, "_res"}, k, result_mask[k], lit_res[k]);
        $display("directed %s: vld=%b sel=%b enq=%b/%b res=%b/%b", lit_name,
                 entry_vld, sel_mask, enq_mask[1], enq_mask[0],
                 result_mask[1], result_mask[0]);
      end
    end
  end

  task automatic directed(input string name, input logic [D-1:0] v, input logic [D-1:0] s,
                          input logic [D-1:0] e0, input logic [D-1:0] e1,
                          input logic [D-1:0] r0, input logic [D-1:0] r1);
    @(posedge clk);
    #1;
    entry_vld = v;
    sel_mask  = s;
`ifdef STATIC_PRIO_SEL_OUT_REG_EN
    @(posedge clk);
    #1;
`endif
    lit_name   = name;
    lit_enq[0] = e0;
    lit_enq[1] = e1;
    lit_res[0] = r0;
    lit_res[1] = r1;
    lit_en     = 1'b1;
    @(negedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    entry_vld = 8'hFF;
    sel_mask  = 8'h00;

    // Reset state: all slots zero (inputs chosen so this holds in both builds).
    repeat (2) @(negedge clk);
    for (int k = 0; k < EW; k++) chk("reset_enq", k, enq_mask[k], 8'h00);
    for (int k = 0; k < SW; k++) chk("reset_res", k, result_mask[k], 8'h00);

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    directed("mixed",   8'b1010_0110, 8'b1010_0100,
             8'b0000_0001, 8'b0000_1000, 8'b0000_0100, 8'b0010_0000);
    directed("all_vld", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    directed("one_cand", 8'h7F, 8'h80, 8'h80, 8'h00, 8'h80, 8'h00);
    directed("all_free", 8'h00, 8'hFF, 8'h01, 8'h02, 8'h01, 8'h02);
    directed("low_one", 8'hFE, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00);
    directed("three_req", 8'hF0, 8'b1011_0000, 8'h01, 8'h02, 8'h10, 8'h20);

`ifdef STATIC_PRIO_SEL_OUT_REG_EN
    // Latency: after switching to 8'hFE the old value must still be visible
    // before the next edge, and the new one right after it.
    @(posedge clk);
    #1;
    entry_vld = 8'hFF;
    sel_mask  = 8'h00;
    @(posedge clk);
    #1;
    entry_vld = 8'hFE;
    #2;
    chk("latency_before", 0, enq_mask[0], 8'h00);
    @(posedge clk);
    #1;
    chk("latency_after", 0, enq_mask[0], 8'h01);

    // Asynchronous clear mid-cycle.
    entry_vld = 8'h00;
    sel_mask  = 8'hFF;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < EW; k++) chk("async_clr_enq", k, enq_mask[k], 8'h00);
    for (int k = 0; k < SW; k++) chk("async_clr_res", k, result_mask[k], 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    // Random sweep: mostly subset requests, sometimes unrelated requests to
    // confirm the selection path ignores the valid bits.
    for (int n = 0; n < NUM_RANDOM; n++) begin
      @(posedge clk);
      #1;
      entry_vld = D'($urandom);
      if ($urandom_range(3) == 0) sel_mask = D'($urandom);
      else                        sel_mask = D'($urandom) & entry_vld;
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
